mul_sequencer: RTL and testbench

Iterative multiply sequencer for the RV32M MUL/MULH/MULHSU/MULHU subset. It borrows the core's shared ALU through an operand/opcode override port and issues one ADD or SUB per cycle to produce the 64-bit product by radix-2 shift-add. Sign handling is done by magnitude conversion before the loop and 64-bit negation after it. It sits beside ALU_Control: the core stalls on `busy_o` while the sequencer's `alu_grant_o` selects its operands and opcode into the ALU.

---
 rtl/mul_sequencer.sv | 121 ++++++++++++
 tb/tb_mul_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: radix-2 shift-add RV32M multiply driven through the shared ALU
module mul_sequencer #(
  parameter int          WIDTH   = 32,
  parameter logic [3:0]  ALU_ADD = 4'b0000,
  parameter logic [3:0]  ALU_SUB = 4'b0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             alu_grant_o,
  output logic [3:0]       alu_operation_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] mcand, mplr, hi, lo;
  logic [2:0] f3;
  logic a_neg, b_neg, neg_res, lo_zero;
  logic [CW-1:0] cnt;
  logic accept, last, carry;
  assign accept = start_i & ~funct3_i[2];
  assign last = cnt == CW'(WIDTH - 1);
  assign carry = alu_result_i < hi;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign result_o = f3 == 3'b000 ? lo : hi;
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  // sequence: fixed walk through every step so latency never depends on operands
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? ABS_A : IDLE;
      ABS_A:   next = ABS_B;
      ABS_B:   next = MUL;
      MUL:     next = last ? NEG_LO : MUL;
      NEG_LO:  next = NEG_HI;
      NEG_HI:  next = DONE;
      default: next = IDLE;
    endcase
  end
  // ALU drive: idle/done leave the ALU parked on a zero ADD
  always_comb begin
    alu_grant_o = 1'b1;
    alu_operation_o = ALU_SUB;
    alu_a_o = '0;
    alu_b_o = '0;
    case (state)
      ABS_A:  alu_b_o = mcand;
      ABS_B:  alu_b_o = mplr;
      MUL: begin
        alu_operation_o = ALU_ADD;
        alu_a_o = hi;
        alu_b_o = lo[0] ? mcand : '0;
      end
      NEG_LO: alu_b_o = lo;
      NEG_HI: begin
        alu_operation_o = ALU_ADD;
        alu_a_o = ~hi;
        alu_b_o = WIDTH'(lo_zero);
      end
      default: begin
        alu_grant_o = 1'b0;
        alu_operation_o = ALU_ADD;
      end
    endcase
  end
  // datapath: magnitudes, shift-add loop, then 64-bit negate as {~hi + (lo==0), -lo}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      mplr <= '0;
      hi <= '0;
      lo <= '0;
      f3 <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      neg_res <= 1'b0;
      lo_zero <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand <= rs1_i;
          mplr <= rs2_i;
          f3 <= funct3_i;
          a_neg <= rs1_i[WIDTH-1] & (funct3_i == 3'b001 | funct3_i == 3'b010);
          b_neg <= rs2_i[WIDTH-1] & (funct3_i == 3'b001);
          neg_res <= (rs1_i[WIDTH-1] & (funct3_i == 3'b001 | funct3_i == 3'b010)) ^ (rs2_i[WIDTH-1] & (funct3_i == 3'b001));
          hi <= '0;
          cnt <= '0;
        end
        ABS_A: if (a_neg) mcand <= alu_result_i;
        ABS_B: lo <= b_neg ? alu_result_i : mplr;
        MUL: begin
          hi <= {carry, alu_result_i[WIDTH-1:1]};
          lo <= {alu_result_i[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end
        NEG_LO: begin
          lo_zero <= lo == '0;
          if (neg_res) lo <= alu_result_i;
        end
        NEG_HI: if (neg_res) hi <= alu_result_i;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for mul_sequencer with an attached ALU model
module tb_mul_sequencer;
  localparam int W = 32;
  localparam int LAT = W + 5;
  localparam int PERIOD = W + 6;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  typedef struct {logic [W-1:0] res; int acc;} exp_t;
  logic clk = 0, reset = 1, start_i = 0;
  logic [2:0] funct3_i = 0;
  logic [W-1:0] rs1_i = 0, rs2_i = 0, alu_result_i, alu_a_o, alu_b_o, result_o;
  logic [3:0] alu_operation_o;
  logic alu_grant_o, busy_o, done_o;
  int cyc = 0, checks = 0, errors = 0, d;
  logic be, de;
  exp_t q[$];

  mul_sequencer #(.WIDTH(W), .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .alu_result_i(alu_result_i),
    .alu_grant_o(alu_grant_o), .alu_operation_o(alu_operation_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o));

  assign alu_result_i = alu_operation_o == ALU_SUB ? alu_a_o - alu_b_o : alu_a_o + alu_b_o;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb, p;
    ea = (f == 3'b001 || f == 3'b010) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = f == 3'b001 ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p = ea * eb;
    return f == 3'b000 ? p[W-1:0] : p[2*W-1:W];
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_wait", busy_o, 0);
  endtask

  task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    funct3_i = f;
    rs1_i = a;
    rs2_i = b;
    start_i = 1;
    @(posedge clk);
    #1 start_i = 0;
    if (!f[2]) q.push_back('{model(f, a, b), cyc - 1});
  endtask

  // monitor: busy/grant/done timing follows from accept cycle, result from the queued model value
  always @(negedge clk) if (!reset) begin
    d = q.size() != 0 ? cyc - q[0].acc : 0;
    be = q.size() != 0 && d >= 1 && d <= LAT;
    de = q.size() != 0 && d == LAT;
    check("busy", busy_o, be);
    check("grant", alu_grant_o, be && d < LAT);
    check("done", done_o, de);
    if (!be) check("alu_idle", {alu_operation_o, alu_a_o, alu_b_o}, 0);
    if (de) begin
      check("result", result_o, q[0].res);
      void'(q.pop_front());
    end
  end

  initial begin
    logic [2:0] f;
    logic [W-1:0] a, b;
    int n;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_grant", alu_grant_o, 0);
    check("rst_result", result_o, 0);
    reset = 0;
    do_op(3'b000, 7, 6);
    do_op(3'b001, 32'hFFFFFFFD, 5);
    do_op(3'b000, 32'hFFFFFFFD, 5);
    do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_op(3'b001, 32'h80000000, 32'h80000000);
    do_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
    do_op(3'b001, 0, 32'h80000000);
    wait_idle();
    do_op(3'b100, 32'h1234, 32'h5678);
    do_op(3'b111, 32'h1, 32'h1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++)
      do_op(3'($urandom_range(0, 3)), $urandom, $urandom);
    wait_idle();
    start_i = 1;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      f = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      funct3_i = f;
      rs1_i = a;
      rs2_i = b;
      @(posedge clk);
      #1;
      if (i % PERIOD == 0) q.push_back('{model(f, a, b), cyc - 1});
    end
    start_i = 0;
    do_op(3'b000, $urandom, $urandom);
    repeat (12) @(posedge clk);
    #2 reset = 1;
    q.delete();
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_grant", alu_grant_o, 0);
    check("arst_result", result_o, 0);
    check("arst_done", done_o, 0);
    @(posedge clk);
    #2 reset = 0;
    do_op(3'b000, 3, 4);
    n = 0;
    while (q.size() != 0 && n < 4 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
